// File: rtl/lcd_pkg.sv
// Shared LCD definitions: op codes, HD44780 instruction bytes, default settling gaps
// and the command arbiter state encoding.
package lcd_pkg;

   typedef enum logic [1:0] {
      OP_INSTR = 2'b00,
      OP_DATA  = 2'b01
   } lcd_op_t;

   localparam logic [7:0] LCD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_HOME    = 8'h02;
   localparam logic [7:0] LCD_ENTRY   = 8'h06;
   localparam logic [7:0] LCD_DISP_ON = 8'h0C;
   localparam logic [7:0] LCD_FUNCSET = 8'h38;
   localparam logic [7:0] LCD_LINE1   = 8'h80;
   localparam logic [7:0] LCD_LINE2   = 8'hC0;

   localparam int LCD_CMD_GAP   = 5000;
   localparam int LCD_CLEAR_GAP = 75000;
   localparam int LCD_GAP_W     = 20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_GAP
   } lcd_arb_state_e;

   // Clear and Home need the long settling time; every other command gets the short one.
   function automatic logic lcd_is_long_cmd(input logic [1:0] op, input logic [7:0] data);
      return (op == OP_INSTR) && ((data == LCD_CLEAR) || (data == LCD_HOME));
   endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Rotating priority encoder: first set candidate at or after ptr, wrapping around.
module lcd_rr_pick
   import lcd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] cand,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [PTR_W-1:0]   win_idx,
   output logic               any
);

   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && cand[idx]) begin
            win[idx] = 1'b1;
            win_idx  = PTR_W'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Shares the lcdIp command port between NUM_REQ requesters with locked bursts and
// HD44780 settling gaps. Define LCD_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module lcd_cmd_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int CMD_GAP   = LCD_CMD_GAP,
   parameter int CLEAR_GAP = LCD_CLEAR_GAP,
   parameter int GAP_W     = LCD_GAP_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [2*NUM_REQ-1:0] req_op,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_lock,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic [1:0]           lcd_op,
   output logic [7:0]           lcd_din,
   output logic                 lcd_send,
   input  logic                 lcd_busy,
   output logic                 arb_idle
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   lcd_arb_state_e       state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d, ack_q, ack_d;
   logic [PTR_W-1:0]     rr_q, rr_d, gidx_q, gidx_d;
   logic                 lock_q, lock_d, send_q, send_d, idle_q, idle_d, wfirst_q, wfirst_d;
   logic [1:0]           op_q, op_d;
   logic [7:0]           din_q, din_d;
   logic [GAP_W-1:0]     gap_q, gap_d;

   logic [NUM_REQ-1:0]   cand, pick_win;
   logic [PTR_W-1:0]     pick_ptr, pick_idx;
   logic                 pick_any;
   logic [1:0]           sel_op;
   logic [7:0]           sel_data;

   // While locked, grant_q still holds the owner, so it doubles as the candidate mask.
   assign cand = lock_q ? (req_valid & grant_q) : req_valid;

`ifdef LCD_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   assign pick_ptr = rr_q;
`endif

   lcd_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .cand    (cand),
      .ptr     (pick_ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      sel_op   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_win[i]) begin
            sel_op   = req_op[2*i +: 2];
            sel_data = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ack_d    = '0;
      send_d   = 1'b0;
      op_d     = op_q;
      din_d    = din_q;
      gidx_d   = gidx_q;
      lock_d   = lock_q;
      rr_d     = rr_q;
      gap_d    = gap_q;
      wfirst_d = wfirst_q;
      case (state_q)
         S_IDLE: begin
            if (pick_any && !lcd_busy) begin
               state_d = S_ISSUE;
               grant_d = pick_win;
               gidx_d  = pick_idx;
               op_d    = sel_op;
               din_d   = sel_data;
               send_d  = 1'b1;
               ack_d   = pick_win;
            end
         end
         S_ISSUE: begin
            lock_d = req_lock[gidx_q];
            if (!req_lock[gidx_q]) begin
               rr_d = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            wfirst_d = 1'b1;
            state_d  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // lcdIp raises busy a cycle after send, so never trust busy on the first cycle.
            if (wfirst_q) begin
               wfirst_d = 1'b0;
            end else if (!lcd_busy) begin
               gap_d   = lcd_is_long_cmd(op_q, din_q) ? GAP_W'(CLEAR_GAP) : GAP_W'(CMD_GAP);
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
               if (!lock_q) grant_d = '0;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      idle_d = (state_d == S_IDLE) && !lock_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         ack_q    <= '0;
         send_q   <= 1'b0;
         op_q     <= '0;
         din_q    <= '0;
         gidx_q   <= '0;
         lock_q   <= 1'b0;
         rr_q     <= '0;
         gap_q    <= '0;
         wfirst_q <= 1'b0;
         idle_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         send_q   <= send_d;
         op_q     <= op_d;
         din_q    <= din_d;
         gidx_q   <= gidx_d;
         lock_q   <= lock_d;
         rr_q     <= rr_d;
         gap_q    <= gap_d;
         wfirst_q <= wfirst_d;
         idle_q   <= idle_d;
      end
   end

   assign req_ack  = ack_q;
   assign grant    = grant_q;
   assign lcd_op   = op_q;
   assign lcd_din  = din_q;
   assign lcd_send = send_q;
   assign arb_idle = idle_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Randomized bench for lcd_cmd_arbiter with a transaction-level arbitration model.
module tb_lcd_cmd_arbiter;

   localparam int N  = 4;
   localparam int CG = 20;
   localparam int KG = 60;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] data;
      logic       lock;
   } cmd_t;

   typedef struct {
      int         cyc;
      int         idx;
      logic [1:0] op;
      logic [7:0] din;
      logic       lock;
      int         blen;
   } sent_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid, req_lock, req_ack, grant;
   logic [2*N-1:0] req_op;
   logic [8*N-1:0] req_data;
   logic [1:0]     lcd_op;
   logic [7:0]     lcd_din;
   logic           lcd_send, lcd_busy, arb_idle;
   logic           busy_model = 1'b0;
   logic           busy_force = 1'b0;
   logic [N-1:0]   pause = '0;

   assign lcd_busy = busy_model | busy_force;

   cmd_t  rq[N][$];
   sent_t slog[$];
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   int    m_ptr = 0;
   int    m_seen = 0;

   lcd_cmd_arbiter #(.NUM_REQ(N), .CMD_GAP(CG), .CLEAR_GAP(KG), .GAP_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_lock  (req_lock),
      .req_ack   (req_ack),
      .grant     (grant),
      .lcd_op    (lcd_op),
      .lcd_din   (lcd_din),
      .lcd_send  (lcd_send),
      .lcd_busy  (lcd_busy),
      .arb_idle  (arb_idle)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   // Requesters: present queue head, drop it the cycle after its ack.
   initial begin
      logic [N-1:0] pend;
      pend      = '0;
      req_valid = '0;
      req_op    = '0;
      req_data  = '0;
      req_lock  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         pend = req_ack;
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && !pause[i]) begin
               req_valid[i]       = 1'b1;
               req_op[2*i +: 2]   = rq[i][0].op;
               req_data[8*i +: 8] = rq[i][0].data;
               req_lock[i]        = rq[i][0].lock;
            end else begin
               req_valid[i] = 1'b0;
               req_lock[i]  = 1'b0;
            end
         end
      end
   end

   // lcdIp stand-in: random busy length after each send; every send is logged.
   initial begin
      sent_t e;
      int    bl;
      bl = 0;
      forever begin
         @(negedge clk);
         if (bl > 0) begin
            bl--;
            if (bl == 0) busy_model = 1'b0;
         end
         if (lcd_send === 1'b1) begin
            e.cyc = cyc;
            e.idx = -1;
            for (int i = 0; i < N; i++)
               if (req_ack[i] === 1'b1) e.idx = (e.idx == -1) ? i : -2;
            e.op   = lcd_op;
            e.din  = lcd_din;
            e.lock = (e.idx >= 0) ? req_lock[e.idx] : 1'b0;
            e.blen = int'($urandom_range(1, 12));
            bl         = e.blen;
            busy_model = 1'b1;
            slog.push_back(e);
         end
      end
   end

   function automatic cmd_t mk(input logic [1:0] op, input logic [7:0] d, input logic lk);
      cmd_t c;
      c.op   = op;
      c.data = d;
      c.lock = lk;
      return c;
   endfunction

   function automatic int gap_of(input logic [1:0] op, input logic [7:0] d);
      return (op === 2'b00 && (d === 8'h01 || d === 8'h02)) ? KG : CG;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_sync();
      for (int k = m_seen; k < slog.size(); k++)
         if (slog[k].idx >= 0 && !slog[k].lock) m_ptr = (slog[k].idx + 1) % N;
      m_seen = slog.size();
   endtask

   task automatic wait_sends(input int n, input int budget, input string nm);
      int k;
      k = 0;
      while (slog.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      total++;
      if (slog.size() < n) begin
         bad++;
         $display("FAIL %s_timeout: sends=%0d need=%0d", nm, slog.size(), n);
      end
   endtask

   task automatic wait_quiet(input string nm);
      int k;
      k = 0;
      while (!(all_empty() && arb_idle === 1'b1 && lcd_busy === 1'b0) && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      total++;
      if (!(all_empty() && arb_idle === 1'b1)) begin
         bad++;
         $display("FAIL %s_quiet_timeout: arb_idle=%b", nm, arb_idle);
      end
      model_sync();
   endtask

   task automatic check_spacing(input int k, input string nm);
      int g, d, lo, hi;
      g  = gap_of(slog[k-1].op, slog[k-1].din);
      d  = slog[k].cyc - slog[k-1].cyc;
      lo = 3 + g + slog[k-1].blen;
      hi = 8 + g + slog[k-1].blen;
      total++;
      if (d < lo || d > hi) begin
         bad++;
         $display("FAIL %s_spacing[%0d]: got %0d cycles want %0d..%0d", nm, k, d, lo, hi);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({grant, req_ack, lcd_send, lcd_op, lcd_din, arb_idle} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: grant=%b ack=%b send=%b op=%b din=%h idle=%b",
                  grant, req_ack, lcd_send, lcd_op, lcd_din, arb_idle);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      total++;
      if (arb_idle !== 1'b1 || grant !== '0) begin
         bad++;
         $display("FAIL reset_release: arb_idle=%b grant=%b want 1/0000", arb_idle, grant);
      end
   endtask

   task automatic test_single();
      int   base;
      cmd_t c2;
      wait_quiet("single");
      base = slog.size();
      c2   = mk(2'b01, 8'($urandom), 1'b0);
      @(posedge clk); #2;
      rq[0].push_back(mk(2'b00, 8'h38, 1'b0));
      rq[0].push_back(c2);
      @(negedge clk); @(negedge clk); #1;
      total++;
      if (lcd_send !== 1'b1 || req_ack !== 4'b0001 || grant !== 4'b0001) begin
         bad++;
         $display("FAIL single_accept: send=%b ack=%b grant=%b want 1/0001/0001", lcd_send, req_ack, grant);
      end
      total++;
      if (lcd_din !== 8'h38 || lcd_op !== 2'b00) begin
         bad++;
         $display("FAIL single_cmd: op=%b din=%h want 00/38", lcd_op, lcd_din);
      end
      @(negedge clk); #1;
      total++;
      if (lcd_send !== 1'b0 || req_ack !== '0) begin
         bad++;
         $display("FAIL single_pulse: send=%b ack=%b want 0/0000", lcd_send, req_ack);
      end
      wait_sends(base + 2, 400, "single");
      if (slog.size() >= base + 2) begin
         check_spacing(base + 1, "single");
         total++;
         if (slog[base+1].idx !== 0 || slog[base+1].din !== c2.data || slog[base+1].op !== 2'b01) begin
            bad++;
            $display("FAIL single_second: idx=%0d din=%h want 0/%h", slog[base+1].idx, slog[base+1].din, c2.data);
         end
      end
      wait_quiet("single_end");
      total++;
      if (grant !== '0) begin
         bad++;
         $display("FAIL single_grant_release: grant=%b want 0000", grant);
      end
   endtask

   task automatic test_gaps();
      int   base;
      cmd_t cl[16];
      cl[0] = mk(2'b00, 8'h01, 1'b0);
      cl[1] = mk(2'b01, 8'h41, 1'b0);
      cl[2] = mk(2'b00, 8'h02, 1'b0);
      cl[3] = mk(2'b01, 8'h01, 1'b0);
      cl[4] = mk(2'b10, 8'h01, 1'b0);
      cl[5] = mk(2'b11, 8'h02, 1'b0);
      cl[6] = mk(2'b00, 8'h38, 1'b0);
      for (int k = 7; k < 16; k++)
         cl[k] = mk(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom), 1'b0);
      wait_quiet("gaps");
      base = slog.size();
      @(posedge clk); #2;
      for (int k = 0; k < 16; k++) rq[1].push_back(cl[k]);
      wait_sends(base + 16, 16 * 120, "gaps");
      if (slog.size() >= base + 16) begin
         for (int k = 0; k < 16; k++) begin
            total++;
            if (slog[base+k].idx !== 1 || slog[base+k].op !== cl[k].op || slog[base+k].din !== cl[k].data) begin
               bad++;
               $display("FAIL gaps_cmd[%0d]: idx=%0d op=%b din=%h want 1/%b/%h",
                        k, slog[base+k].idx, slog[base+k].op, slog[base+k].din, cl[k].op, cl[k].data);
            end
            if (k > 0) check_spacing(base + k, "gaps");
         end
      end
      wait_quiet("gaps_end");
   endtask

   task automatic test_round_robin();
      int   base, p, j;
      int   rem[N], used[N], ei[16];
      cmd_t cl[N][4];
      cmd_t ec[16];
      wait_quiet("rr");
      base = slog.size();
      for (int i = 0; i < N; i++) begin
         rem[i]  = 4;
         used[i] = 0;
         for (int k = 0; k < 4; k++) cl[i][k] = mk(2'b01, 8'($urandom), 1'b0);
      end
      p = m_ptr;
      for (int n = 0; n < 16; n++) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
         p = 0;
`endif
         j = -1;
         for (int k = 0; k < N; k++)
            if (j < 0 && rem[(p + k) % N] > 0) j = (p + k) % N;
         ei[n] = j;
         ec[n] = cl[j][used[j]];
         used[j]++;
         rem[j]--;
         p = (j + 1) % N;
      end
      @(posedge clk); #2;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++) rq[i].push_back(cl[i][k]);
      wait_sends(base + 16, 16 * 120, "rr");
      if (slog.size() >= base + 16) begin
         for (int n = 0; n < 16; n++) begin
            total++;
            if (slog[base+n].idx !== ei[n] || slog[base+n].din !== ec[n].data) begin
               bad++;
               $display("FAIL rr_order[%0d]: idx=%0d din=%h want %0d/%h",
                        n, slog[base+n].idx, slog[base+n].din, ei[n], ec[n].data);
            end
         end
      end
      wait_quiet("rr_end");
   endtask

   task automatic test_locked_burst();
      int   base, n;
      cmd_t bl[18];
      cmd_t r0[2];
      bl[0] = mk(2'b00, 8'h80, 1'b1);
      for (int k = 1; k < 17; k++) bl[k] = mk(2'b01, 8'($urandom), 1'b1);
      bl[17] = mk(2'b01, 8'($urandom), 1'b0);
      r0[0]  = mk(2'b01, 8'($urandom), 1'b0);
      r0[1]  = mk(2'b00, 8'h0C, 1'b0);
      wait_quiet("burst");
      base = slog.size();
      @(posedge clk); #2;
      for (int k = 0; k < 18; k++) rq[2].push_back(bl[k]);
      wait_sends(base + 1, 200, "burst_first");
      @(posedge clk); #2;
      rq[0].push_back(r0[0]);
      rq[0].push_back(r0[1]);
      wait_sends(base + 5, 600, "burst_pre_pause");
      @(posedge clk); #2;
      pause[2] = 1'b1;
      n = slog.size();
      repeat (1000) @(negedge clk);
      #1;
      total++;
      if (slog.size() != n) begin
         bad++;
         $display("FAIL pause_no_send: sends=%0d want %0d", slog.size(), n);
      end
      total++;
      if (arb_idle !== 1'b0) begin
         bad++;
         $display("FAIL pause_lock_held: arb_idle=%b want 0", arb_idle);
      end
      @(posedge clk); #2;
      pause[2] = 1'b0;
      wait_sends(base + 20, 20 * 120, "burst");
      if (slog.size() >= base + 20) begin
         for (int k = 0; k < 20; k++) begin
            int   ex;
            cmd_t c;
            ex = (k < 18) ? 2 : 0;
            c  = (k < 18) ? bl[k] : r0[k-18];
            total++;
            if (slog[base+k].idx !== ex || slog[base+k].op !== c.op || slog[base+k].din !== c.data) begin
               bad++;
               $display("FAIL burst_seq[%0d]: idx=%0d op=%b din=%h want %0d/%b/%h",
                        k, slog[base+k].idx, slog[base+k].op, slog[base+k].din, ex, c.op, c.data);
            end
         end
      end
      wait_quiet("burst_end");
   endtask

   task automatic test_busy_hold();
      int base;
      wait_quiet("busy");
      base = slog.size();
      @(posedge clk); #2;
      busy_force = 1'b1;
      rq[3].push_back(mk(2'b01, 8'($urandom), 1'b0));
      repeat (30) @(negedge clk);
      #1;
      total++;
      if (slog.size() != base || req_ack !== '0) begin
         bad++;
         $display("FAIL busy_block: sends=%0d ack=%b want %0d/0000", slog.size(), req_ack, base);
      end
      @(posedge clk); #2;
      busy_force = 1'b0;
      @(negedge clk); #1;
      total++;
      if (lcd_send !== 1'b0) begin
         bad++;
         $display("FAIL busy_early_send: send=%b want 0", lcd_send);
      end
      @(negedge clk); #1;
      total++;
      if (lcd_send !== 1'b1 || req_ack !== 4'b1000) begin
         bad++;
         $display("FAIL busy_release_accept: send=%b ack=%b want 1/1000", lcd_send, req_ack);
      end
      wait_quiet("busy_end");
   endtask

   task automatic test_mid_gap_reset();
      int base;
      wait_quiet("rst");
      base = slog.size();
      @(posedge clk); #2;
      rq[2].push_back(mk(2'b01, 8'($urandom), 1'b0));
      wait_sends(base + 1, 200, "rst_cmd");
      if (slog.size() > base) repeat (slog[base].blen + 6) @(negedge clk);
      #1;
      total++;
      if (grant !== 4'b0100 || arb_idle !== 1'b0) begin
         bad++;
         $display("FAIL gap_grant_held: grant=%b idle=%b want 0100/0", grant, arb_idle);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({grant, req_ack, lcd_send, lcd_op, lcd_din, arb_idle} !== '0) begin
         bad++;
         $display("FAIL midgap_reset_outputs: grant=%b ack=%b send=%b op=%b din=%h idle=%b",
                  grant, req_ack, lcd_send, lcd_op, lcd_din, arb_idle);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      reset  = 1'b0;
      m_ptr  = 0;
      m_seen = slog.size();
      @(negedge clk); @(negedge clk); #1;
      total++;
      if (arb_idle !== 1'b1 || grant !== '0 || slog.size() != base + 1) begin
         bad++;
         $display("FAIL midgap_release: idle=%b grant=%b sends=%0d want 1/0000/%0d",
                  arb_idle, grant, slog.size(), base + 1);
      end
      @(posedge clk); #2;
      rq[3].push_back(mk(2'b01, 8'($urandom), 1'b0));
      rq[1].push_back(mk(2'b01, 8'($urandom), 1'b0));
      wait_sends(base + 3, 300, "rst_after");
      if (slog.size() >= base + 3) begin
         total++;
         if (slog[base+1].idx !== 1 || slog[base+2].idx !== 3) begin
            bad++;
            $display("FAIL reset_rr_ptr: order=%0d,%0d want 1,3", slog[base+1].idx, slog[base+2].idx);
         end
      end
      wait_quiet("rst_end");
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_single();
      test_gaps();
      test_round_robin();
      test_locked_burst();
      test_busy_hold();
      test_mid_gap_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Shares the single lcdIp command port between up to NUM_REQ independent command sources, such as the power-up init sequencer, the two-line message writer and the alert overlay. Each requester issues one command at a time: an instruction or data byte plus a lock bit. The arbiter grants round-robin, holds the port for a locked burst, drives lcdIp's `userOp/send/inputCommand`, and enforces the HD44780 post-command settling gap. It sits between the requesters and `lcdIp` inside the LCD top level.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `CMD_GAP`, 5000: settling cycles after an ordinary command (100 µs at 50 MHz).
- `CLEAR_GAP`, 75000: settling cycles after Clear (0x01) or Home (0x02) instructions (1.5 ms).
- `GAP_W`, 20: gap counter width; must hold CLEAR_GAP.

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a command pending.
- `req_op` in 2*NUM_REQ: per-requester op; 2'b00 = instruction (RS=0), 2'b01 = data (RS=1).
- `req_data` in 8*NUM_REQ: per-requester command/data byte.
- `req_lock` in NUM_REQ: keep the grant after this command.
- `req_ack` out NUM_REQ: one-cycle accept pulse; the requester may change its command the next cycle.
- `grant` out NUM_REQ: one-hot current owner (0 when idle and unlocked).
- `lcd_op` out 2: to lcdIp `userOp`.
- `lcd_din` out 8: to lcdIp `inputCommand`.
- `lcd_send` out 1: to lcdIp `send`, one-cycle pulse.
- `lcd_busy` in 1: from lcdIp `busy`.
- `arb_idle` out 1: high in S_IDLE with no lock held.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT_BUSY, S_GAP.
- **S_IDLE.**
  - Candidates: the lock owner only, if a lock is held; otherwise all requesters with `req_valid`.
  - Choose the first candidate at or after the round-robin pointer `rr_ptr`, wrapping around.
  - If a candidate exists and `lcd_busy`=0: capture op and data, set `grant`, go to S_ISSUE.
- **S_ISSUE** (one cycle):
  - Pulse `lcd_send` and `req_ack[g]`.
  - Latch the lock for g: held iff `req_lock[g]`=1.
  - If unlocked, set `rr_ptr` = g+1 mod NUM_REQ.
  - Go to S_WAIT_BUSY.
- **S_WAIT_BUSY.** Stay at least 2 cycles; leave when `lcd_busy`=0. Load the gap counter with CLEAR_GAP if the captured op is 2'b00 and data is 0x01 or 0x02, else CMD_GAP. Go to S_GAP.
- **S_GAP.** Count down to 0, then go to S_IDLE. `grant` stays asserted through S_GAP.
- **Lock hold.** While a lock is held and the owner deasserts `req_valid`, the arbiter waits in S_IDLE indefinitely; other requesters are starved by design.
- **Simultaneous events.** If all requesters assert in the same cycle, only one is accepted; the others hold valid and are served in rotation order.
- **Op validity.** `req_op` values 2'b10/2'b11 are forwarded unmodified; lcdIp defines their meaning.
- **Reset.**
  - All outputs 0, `rr_ptr`=0, lock cleared, state S_IDLE.
  - Reset mid-gap or mid-burst drops the command in flight; no ack is issued for it.

## Timing
- **Accept latency.** Valid seen in S_IDLE at cycle t (lcd_busy=0) → `lcd_send` and `req_ack` both at t+1.
- `lcd_op`/`lcd_din` are stable from t+1 until the next S_ISSUE.
- **Minimum command spacing.** `lcd_send` to next `lcd_send` ≥ 3 + GAP + busy duration cycles.
- **Back-to-back requests.** A requester holding valid after ack is re-evaluated in the S_IDLE cycle following the gap.
- **Requester rule.** Must hold `req_op`/`req_data` stable while `req_valid` is high and ack has not been seen.

## Configuration
- `LCD_ARB_FIXED_PRIO_EN`
  - **Defined:** the rotation pointer is ignored and the lowest index wins. Lock semantics are unchanged.
  - **Undefined:** round-robin as above (default).

## Structure
- **Shared package `lcd_pkg`:**
  - `lcd_op_t` (OP_INSTR=2'b00, OP_DATA=2'b01).
  - Instruction constants: LCD_CLEAR=8'h01, LCD_HOME=8'h02, LCD_ENTRY=8'h06, LCD_DISP_ON=8'h0C, LCD_FUNCSET=8'h38, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - Default gap constants.
  - State enum `lcd_arb_state_e`.
- **Sub-module `lcd_rr_pick`:** combinational rotate-and-priority-encode over NUM_REQ (candidates, pointer → one-hot winner, valid).
- **Gap counter:** kept inline.

## Test plan
- **Single instruction.** Req0 sends op=00, data=0x38 with lcd_busy modelled 10 cycles → one `lcd_send` at t+1 with lcd_din=0x38 and `req_ack[0]`; next send is no earlier than 5000 cycles after busy falls.
- **Clear gap.** Req1 sends data 0x01 (instr) → gap of 75000 cycles. The same test with 0x41 as data op → 5000 cycles.
- **Round-robin.** Req0..3 all valid continuously with 4 commands each → ack order 0,1,2,3,0,1,…. With `LCD_ARB_FIXED_PRIO_EN` defined, all four of req0's commands are acked first.
- **Locked burst.** Req2 sends 0x80 locked, 16 data bytes locked, last byte unlocked, while req0 stays valid → req0 gets no ack until the 18th req2 ack.
- **Owner pause.** The lock owner drops valid for 1000 cycles → no `lcd_send`; burst resumes when valid returns.
- **Mid-gap reset.** Assert reset mid-S_GAP → all outputs 0 next cycle, `arb_idle`=1 after release, and the first pending request is granted from index 0.
